// File: rtl/bcd_pkg.sv
// Shared constants and FSM state type for the sequential binary-to-BCD converter.
package bcd_pkg;

    localparam int unsigned N_BITS   = 20;
    localparam int unsigned N_DIGITS = 6;
    localparam int unsigned MAX_DEC  = 999999;
    localparam int unsigned BCD_W    = 4 * N_DIGITS;
    localparam int unsigned ITER_W   = $clog2(N_BITS);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        HOLD  = 2'd2
    } state_t;

endpackage

// File: rtl/bcd_digit_adj.sv
// One double-dabble correction: a BCD nibble of 5 or more gets +3 before the shift.
module bcd_digit_adj (
    input  logic [3:0] din,
    output logic [3:0] dout
);

    // din is at most 9 here, so din + 3 never wraps the nibble.
    assign dout = (din >= 4'd5) ? din + 4'd3 : din;

endmodule

// File: rtl/bcd_seq_converter.sv
// Sequential double-dabble binary-to-BCD converter with saturation and a
// leading-zero blank mask; one iteration per clock, results held until taken.
module bcd_seq_converter
    import bcd_pkg::*;
#(
    parameter int unsigned N_BITS   = bcd_pkg::N_BITS,
    parameter int unsigned N_DIGITS = bcd_pkg::N_DIGITS,
    parameter int unsigned MAX_DEC  = bcd_pkg::MAX_DEC
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [N_BITS-1:0]       in_bin,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [4*N_DIGITS-1:0]   out_bcd,
    output logic [N_DIGITS-1:0]     out_blank,
    output logic                    out_ovf
);

    localparam int unsigned          BCD_W     = 4 * N_DIGITS;
    localparam int unsigned          ITER_W    = $clog2(N_BITS);
    localparam logic [N_BITS-1:0]    MAX_BIN   = N_BITS'(MAX_DEC);
    localparam logic [ITER_W-1:0]    LAST_ITER = ITER_W'(N_BITS - 1);
    localparam logic [N_DIGITS-1:0]  BLANK_RST = {{(N_DIGITS-1){1'b1}}, 1'b0};

    state_t                   state, state_nxt;
    logic [N_BITS-1:0]        shift_q;
    logic [BCD_W-1:0]         digits_q;
    logic [ITER_W-1:0]        cnt_q;
    logic                     ovf_q;

    logic                     accept;
    logic                     last_iter;
    logic                     in_ovf;
    logic [BCD_W-1:0]         adj_digits;
    logic [BCD_W+N_BITS-1:0]  shifted;
    logic [BCD_W-1:0]         digits_nxt;
    logic [N_BITS-1:0]        shift_nxt;
    logic [N_DIGITS-1:0]      blank_nxt;
    logic                     zero_above;

    assign in_ready  = (state == IDLE);
    assign accept    = (state == IDLE) && in_valid;
    assign last_iter = (state == SHIFT) && (cnt_q == LAST_ITER);
    assign in_ovf    = (in_bin > MAX_BIN);

    for (genvar g = 0; g < N_DIGITS; g++) begin : g_adj
        bcd_digit_adj u_adj (
            .din  (digits_q[4*g +: 4]),
            .dout (adj_digits[4*g +: 4])
        );
    end

    // The top bit of the adjusted digits falls off the end; it is always 0
    // because the input is saturated to a value that fits in N_DIGITS digits.
    assign shifted    = {adj_digits, shift_q} << 1;
    assign digits_nxt = shifted[BCD_W+N_BITS-1:N_BITS];
    assign shift_nxt  = shifted[N_BITS-1:0];

    // NOTE: every variable an always_comb writes gets a value before any
    // branch or loop, so no path can leave it unassigned and infer a latch.
    always_comb begin
        blank_nxt  = '0;
        zero_above = 1'b1;
        for (int i = N_DIGITS - 1; i >= 1; i--) begin
            zero_above   = zero_above && (digits_nxt[4*i +: 4] == 4'd0);
            blank_nxt[i] = zero_above;
        end
    end

    // NOTE: clocked blocks use non-blocking assignments only, so every
    // register samples the pre-edge value of its inputs regardless of order.
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (in_valid)  state_nxt = SHIFT;
            SHIFT:   if (last_iter) state_nxt = HOLD;
            HOLD:    if (out_ready) state_nxt = IDLE;
            default:                state_nxt = IDLE;
        endcase
    end

    // NOTE: the working shift/digit registers carry no reset; they are fully
    // loaded at every acceptance and never reach the outputs before that.
    always_ff @(posedge clk) begin
        if (accept) begin
            shift_q  <= in_ovf ? MAX_BIN : in_bin;
            digits_q <= '0;
        end else if (state == SHIFT) begin
            shift_q  <= shift_nxt;
            digits_q <= digits_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q     <= '0;
            ovf_q     <= 1'b0;
            out_valid <= 1'b0;
            out_bcd   <= '0;
            out_blank <= BLANK_RST;
            out_ovf   <= 1'b0;
        end else begin
            if (accept) begin
                cnt_q <= '0;
                ovf_q <= in_ovf;
            end else if (state == SHIFT) begin
                cnt_q <= cnt_q + 1'b1;
            end

            // Outputs move only at completion, so no partial digits are shown.
            if (last_iter) begin
                out_bcd   <= digits_nxt;
                out_blank <= blank_nxt;
                out_ovf   <= ovf_q;
                out_valid <= 1'b1;
            end else if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule
